// File: rtl/atm_timer_pkg.sv
// -----------------------------------------------------------------------------
// atm_timer_pkg
// Shared types and helpers for the ATM controller timer bank.
//   chan_state_t  : per-channel timer state (IDLE, RUN, PAUSE, DONE)
//   thr_sel_width : width of the threshold-select bus for a given channel count
//   sanitize_thr  : maps a programmed threshold of 0 onto 1
// -----------------------------------------------------------------------------
package atm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } chan_state_t;

    // A single-channel bank still gets a 1-bit select so the port never collapses.
    localparam int THR_SEL_MIN_W = 1;

    // Widest counter the sanitize helper handles.
    localparam int MAX_CNT_W = 64;

    function automatic int thr_sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : THR_SEL_MIN_W;
    endfunction

    // A threshold of 0 would never match counter == thr-1 sensibly, so it
    // behaves as 1 (expiry on the first counted edge).
    function automatic logic [MAX_CNT_W-1:0] sanitize_thr(input logic [MAX_CNT_W-1:0] thr);
        return (thr == '0) ? MAX_CNT_W'(1) : thr;
    endfunction

endpackage

// File: rtl/atm_timer_chan.sv
// -----------------------------------------------------------------------------
// atm_timer_chan
// One inactivity/session timer channel: state machine, up-counter, threshold
// register, sticky expired flag and one-cycle timeout pulse.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : clear counter, enter RUN, sample periodic
//   cancel        : go IDLE, clear counter and expired
//   kick          : clear counter while RUN/PAUSE, state unchanged
//   pause         : level, hold counter while high
//   periodic      : mode sampled at start (1 = auto-reload)
//   thr_wr        : load thr_data into the threshold register
//   thr_data      : new threshold
//   ack           : clear expired (an expiry on the same edge wins)
//   time_out      : registered one-cycle expiry pulse
//   expired       : registered sticky expiry flag
//   running       : registered, high in RUN or PAUSE
// -----------------------------------------------------------------------------
module atm_timer_chan
    import atm_timer_pkg::*;
#(
    parameter int          CNT_W         = 32,
    parameter int unsigned DEF_THRESHOLD = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             kick,
    input  logic             pause,
    input  logic             periodic,
    input  logic             thr_wr,
    input  logic [CNT_W-1:0] thr_data,
    input  logic             ack,
    output logic             time_out,
    output logic             expired,
    output logic             running
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] thr_last;
    logic             mode_q, mode_d;
    logic             expired_d, time_out_d, running_d;
    logic             active;

    // Counter value on which expiry fires; compares use the registered
    // threshold, so a write affects compares from the following cycle.
    assign thr_last = CNT_W'(sanitize_thr(MAX_CNT_W'(thr_q))) - CNT_W'(1);
    assign active   = (state_q == RUN) || (state_q == PAUSE);

    // Priority on one edge: cancel > start > kick > pause > count.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        thr_d      = thr_wr ? thr_data : thr_q;
        expired_d  = expired & ~ack;
        time_out_d = 1'b0;

        if (cancel) begin
            state_d   = IDLE;
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            mode_d  = periodic;
        end else if (kick && active) begin
            cnt_d = '0;
        end else if (active) begin
            if (pause) begin
                // Paused edges neither count nor compare.
                state_d = PAUSE;
            end else begin
                state_d = RUN;
                if (cnt_q == thr_last) begin
                    cnt_d      = '0;
                    time_out_d = 1'b1;
                    expired_d  = 1'b1;
                    if (!mode_q) begin
                        state_d = DONE;
                    end
                end else begin
                    // Wraps modulo 2^CNT_W if the threshold was lowered
                    // below the running count.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        running_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            thr_q    <= CNT_W'(DEF_THRESHOLD);
            mode_q   <= 1'b0;
            expired  <= 1'b0;
            time_out <= 1'b0;
            running  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            mode_q   <= mode_d;
            expired  <= expired_d;
            time_out <= time_out_d;
            running  <= running_d;
        end
    end

endmodule

// File: rtl/atm_timer_bank.sv
// -----------------------------------------------------------------------------
// atm_timer_bank
// Bank of N_CH independent inactivity/session timers for the ATM controller.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : per-channel start/restart
//   cancel       : per-channel stop and clear
//   kick         : per-channel counter restart without stopping
//   pause        : per-channel level hold
//   periodic     : per-channel mode, sampled at start
//   thr_we       : threshold write strobe
//   thr_sel      : channel receiving the write (>= N_CH is ignored)
//   thr_data     : threshold value
//   ack          : per-channel sticky-flag clear
//   time_out     : per-channel one-cycle expiry pulse
//   expired      : per-channel sticky expiry flag
//   running      : per-channel RUN/PAUSE indicator
//   any_expired  : OR of expired
// CNT_W may be at most 64.
// -----------------------------------------------------------------------------
module atm_timer_bank
    import atm_timer_pkg::*;
#(
    parameter int          N_CH          = 4,
    parameter int          CNT_W         = 32,
    parameter int unsigned DEF_THRESHOLD = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CH-1:0]                  start,
    input  logic [N_CH-1:0]                  cancel,
    input  logic [N_CH-1:0]                  kick,
    input  logic [N_CH-1:0]                  pause,
    input  logic [N_CH-1:0]                  periodic,
    input  logic                             thr_we,
    input  logic [thr_sel_width(N_CH)-1:0]   thr_sel,
    input  logic [CNT_W-1:0]                 thr_data,
    input  logic [N_CH-1:0]                  ack,
    output logic [N_CH-1:0]                  time_out,
    output logic [N_CH-1:0]                  expired,
    output logic [N_CH-1:0]                  running,
    output logic                             any_expired
);

    localparam int SEL_W = thr_sel_width(N_CH);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic thr_wr;

        // Out-of-range selects match no channel, so the write is dropped.
        assign thr_wr = thr_we && (thr_sel == SEL_W'(i));

        atm_timer_chan #(
            .CNT_W         (CNT_W),
            .DEF_THRESHOLD (DEF_THRESHOLD)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .start    (start[i]),
            .cancel   (cancel[i]),
            .kick     (kick[i]),
            .pause    (pause[i]),
            .periodic (periodic[i]),
            .thr_wr   (thr_wr),
            .thr_data (thr_data),
            .ack      (ack[i]),
            .time_out (time_out[i]),
            .expired  (expired[i]),
            .running  (running[i])
        );
    end

    assign any_expired = |expired;

endmodule
